// File: rtl/loopback_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : loopback_pkg
//  Desc     : Shared types and codes for the loopback BER test sequencer
//  Revision : 1.0  initial release
// ============================================================================
package loopback_pkg;

  localparam int CNT_W_DEFAULT = 48;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHAIN_RST = 3'd1,
    S_WARMUP    = 3'd2,
    S_LOCK      = 3'd3,
    S_MEASURE   = 3'd4,
    S_FLUSH     = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  typedef logic [1:0] status_t;

  localparam status_t ST_NONE    = 2'd0;
  localparam status_t ST_PASS    = 2'd1;
  localparam status_t ST_FAIL    = 2'd2;
  localparam status_t ST_TIMEOUT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/loopback_ber_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : loopback_ber_ctrl_if
//  Desc     : Control, checker and result signals of the BER test sequencer
//  Revision : 1.0  initial release
// ============================================================================
interface loopback_ber_ctrl_if
  import loopback_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int CNT_W = CNT_W_DEFAULT
);
  logic             start;
  logic             abort;
  logic [31:0]      window_words;
  logic [CNT_W-1:0] err_limit;
  logic             chk_valid;
  logic [NBITS-1:0] chk_err;
  logic             chain_rst;
  logic             busy;
  logic             locked;
  logic             done;
  status_t          status;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] bit_err_cnt;

  // Test controller side: issues commands, feeds checker results, reads status
  modport master (
    output start, abort, window_words, err_limit, chk_valid, chk_err,
    input  chain_rst, busy, locked, done, status, word_cnt, bit_err_cnt
  );

  // Sequencer side
  modport slave (
    input  start, abort, window_words, err_limit, chk_valid, chk_err,
    output chain_rst, busy, locked, done, status, word_cnt, bit_err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/popcount_reg.sv
`default_nettype none
// ============================================================================
//  Module   : popcount_reg
//  Desc     : Ones count of an error vector with a registered, enabled output
//  Revision : 1.0  initial release
// ============================================================================
module popcount_reg #(
  parameter int NBITS = 32,
  parameter int CW    = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NBITS-1:0] din,
  output logic [CW-1:0]    cnt
);
  logic [CW-1:0] sum;

  // Combinational ones count of the input word
  always_comb begin
    sum = '0;
    for (int i = 0; i < NBITS; i++) begin
      sum = sum + CW'(din[i]);
    end
  end

  // Capture the count when a word is presented, hold otherwise
  always_ff @(posedge clk) begin
    if (!rst)    cnt <= '0;
    else if (en) cnt <= sum;
  end
endmodule
`default_nettype wire

// File: rtl/loopback_ber_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : loopback_ber_ctrl
//  Desc     : Loopback chain test sequencer: chain reset, warm-up, PRBS lock,
//             windowed word / bit-error counting and pass/fail/timeout result
//  Revision : 1.0  initial release
// ============================================================================
module loopback_ber_ctrl
  import loopback_pkg::*;
#(
  parameter int NBITS            = 32,
  parameter int CNT_W            = CNT_W_DEFAULT,
  parameter int CHAIN_RST_CYCLES = 16,
  parameter int WARMUP_CYCLES    = 256,
  parameter int LOCK_WORDS       = 64,
  parameter int LOCK_TIMEOUT     = 65536
) (
  input  logic               core_clk,
  input  logic               rst,
  loopback_ber_ctrl_if.slave bus
);
  localparam int PW    = $clog2(NBITS + 1);
  localparam int RUN_W = $clog2(LOCK_WORDS + 1);

  state_t           state, state_nxt;
  logic [31:0]      phase;          // cycles in timed states, words in MEASURE
  logic [RUN_W-1:0] run;
  logic [31:0]      win;
  logic [CNT_W-1:0] lim;
  logic [CNT_W-1:0] words, bit_errs;
  logic [CNT_W:0]   word_sum, err_sum;
  logic [CNT_W-1:0] words_sat, bit_errs_sat, err_final;
  logic [PW-1:0]    pc_cnt;
  logic             pc_en, pc_vld;
  logic             accept_start, word_clean, meas_upd;
  logic             chain_rst_q, locked_q, done_q;
  status_t          status_q;

  assign accept_start = bus.start && !bus.abort && (state == S_IDLE || state == S_DONE);
  assign word_clean   = bus.chk_valid && (bus.chk_err == '0);
  assign pc_en        = (state == S_MEASURE) && bus.chk_valid;
  // Counters move one cycle after their word, so FLUSH still absorbs the last one
  assign meas_upd     = pc_vld && (state == S_MEASURE || state == S_FLUSH);

  popcount_reg #(.NBITS(NBITS), .CW(PW)) u_popcount (
    .clk (core_clk),
    .rst (rst),
    .en  (pc_en),
    .din (bus.chk_err),
    .cnt (pc_cnt)
  );

  // Saturating next values of the measurement counters
  always_comb begin
    word_sum     = {1'b0, words} + (CNT_W + 1)'(1);
    err_sum      = {1'b0, bit_errs} + (CNT_W + 1)'(pc_cnt);
    words_sat    = word_sum[CNT_W] ? '1 : word_sum[CNT_W-1:0];
    bit_errs_sat = err_sum[CNT_W]  ? '1 : err_sum[CNT_W-1:0];
    err_final    = pc_vld ? bit_errs_sat : bit_errs;
  end

  // Next-state decode; abort overrides every other transition
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (accept_start) state_nxt = S_CHAIN_RST;
      S_CHAIN_RST:    if (phase == 32'(CHAIN_RST_CYCLES - 1)) state_nxt = S_WARMUP;
      S_WARMUP:       if (phase == 32'(WARMUP_CYCLES - 1)) state_nxt = S_LOCK;
      S_LOCK: begin
        if (word_clean && run == RUN_W'(LOCK_WORDS - 1)) state_nxt = S_MEASURE;
        else if (phase == 32'(LOCK_TIMEOUT - 1))          state_nxt = S_DONE;
      end
      S_MEASURE:      if (bus.chk_valid && phase == win - 32'd1) state_nxt = S_FLUSH;
      S_FLUSH:        state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
    if (bus.abort) state_nxt = S_IDLE;
  end

  // State register
  always_ff @(posedge core_clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Phase counter restarts on every state change; lock run tracks clean words
  always_ff @(posedge core_clk) begin
    if (!rst) begin
      phase <= '0;
      run   <= '0;
    end else begin
      if (state_nxt != state)                          phase <= '0;
      else if (state != S_MEASURE || bus.chk_valid)    phase <= phase + 32'd1;
      if (state != S_LOCK)                             run <= '0;
      else if (word_clean)                             run <= run + RUN_W'(1);
      else if (bus.chk_valid)                          run <= '0;
    end
  end

  // Test configuration captured on an accepted start; zero-length window means one word
  always_ff @(posedge core_clk) begin
    if (!rst) begin
      win <= 32'd1;
      lim <= '0;
    end else if (accept_start) begin
      win <= (bus.window_words == 32'd0) ? 32'd1 : bus.window_words;
      lim <= bus.err_limit;
    end
  end

  // Word and bit-error counters, cleared on start, fed by the registered popcount
  always_ff @(posedge core_clk) begin
    if (!rst) begin
      words    <= '0;
      bit_errs <= '0;
      pc_vld   <= 1'b0;
    end else begin
      pc_vld <= pc_en;
      if (accept_start) begin
        words    <= '0;
        bit_errs <= '0;
      end else if (meas_upd) begin
        words    <= words_sat;
        bit_errs <= bit_errs_sat;
      end
    end
  end

  // Registered outputs: chain reset, done pulse, lock flag and result status
  always_ff @(posedge core_clk) begin
    if (!rst) begin
      chain_rst_q <= 1'b1;
      done_q      <= 1'b0;
      locked_q    <= 1'b0;
      status_q    <= ST_NONE;
    end else begin
      chain_rst_q <= (state_nxt == S_IDLE) || (state_nxt == S_CHAIN_RST);
      done_q      <= (state_nxt == S_DONE) && (state != S_DONE);
      if (accept_start)                                      locked_q <= 1'b0;
      else if (state == S_LOCK && state_nxt == S_MEASURE)    locked_q <= 1'b1;
      if (accept_start || bus.abort)                         status_q <= ST_NONE;
      else if (state == S_LOCK && state_nxt == S_DONE)       status_q <= ST_TIMEOUT;
      else if (state == S_FLUSH)                             status_q <= (err_final <= lim) ? ST_PASS : ST_FAIL;
    end
  end

  assign bus.chain_rst   = chain_rst_q;
  assign bus.busy        = (state != S_IDLE) && (state != S_DONE);
  assign bus.locked      = locked_q;
  assign bus.done        = done_q;
  assign bus.status      = status_q;
  assign bus.word_cnt    = words;
  assign bus.bit_err_cnt = bit_errs;
endmodule
`default_nettype wire

// File: tb/tb_loopback_ber_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_loopback_ber_ctrl
//  Desc     : Directed self-checking bench for loopback_ber_ctrl
//  Revision : 1.0  initial release
// ============================================================================
module tb_loopback_ber_ctrl;
  import loopback_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  loopback_ber_ctrl_if #(.NBITS(32), .CNT_W(48)) bus ();

  loopback_ber_ctrl #(
    .NBITS(32), .CNT_W(48), .CHAIN_RST_CYCLES(16), .WARMUP_CYCLES(256),
    .LOCK_WORDS(64), .LOCK_TIMEOUT(65536)
  ) dut (
    .core_clk (clk),
    .rst      (rst),
    .bus      (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start and measure the chain reset length; returns at chain_rst fall
  task automatic start_chain(input string tag, input logic [31:0] win, input logic [47:0] lim);
    int n;
    bus.window_words = win;
    bus.err_limit    = lim;
    bus.chk_valid    = 1'b1;
    bus.chk_err      = '0;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    check($sformatf("%s_busy_after_start", tag), bus.busy, 1);
    check($sformatf("%s_cnt_cleared", tag), {bus.word_cnt, bus.status}, 0);
    n = 0;
    while (bus.chain_rst && n < 100) begin n++; tick(); end
    check($sformatf("%s_chain_rst_len", tag), n, 16);
  endtask

  // Clean stream from chain release: lock after 256 warm-up + 64 words
  task automatic start_and_lock(input string tag, input logic [31:0] win, input logic [47:0] lim);
    int n;
    start_chain(tag, win, lim);
    n = 0;
    while (!bus.locked && n < 2000) begin n++; tick(); end
    check($sformatf("%s_lock_latency", tag), n, 320);
  endtask

  // Feed the measurement window from the first MEASURE cycle and check the result
  task automatic measure(input string tag, input int nwords, input int nerr, input logic [31:0] vec,
                         input int start_at, input logic [47:0] exp_words,
                         input logic [47:0] exp_bits, input logic [1:0] exp_status);
    for (int i = 0; i < nwords; i++) begin
      bus.chk_err = (i < nerr) ? vec : 32'd0;
      bus.start   = (i == start_at);
      tick();
    end
    bus.start   = 1'b0;
    bus.chk_err = 32'hFFFF_FFFF;  // valid words in FLUSH/DONE must be ignored
    check($sformatf("%s_flush_nodone", tag), {bus.done, bus.busy}, 2'b01);
    tick();
    bus.chk_err = '0;
    check($sformatf("%s_done", tag), {bus.done, bus.busy}, 2'b10);
    check($sformatf("%s_status", tag), bus.status, exp_status);
    check($sformatf("%s_word_cnt", tag), bus.word_cnt, exp_words);
    check($sformatf("%s_bit_err_cnt", tag), bus.bit_err_cnt, exp_bits);
    tick();
    check($sformatf("%s_done_pulse_hold", tag), {bus.done, bus.status, bus.word_cnt},
          {1'b0, exp_status, exp_words});
  endtask

  initial begin
    int seen;
    rst = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.window_words = '0; bus.err_limit = '0;
    bus.chk_valid = 1'b0; bus.chk_err = '0;
    tick(); tick();
    check("reset_outputs", {bus.chain_rst, bus.busy, bus.locked, bus.done, bus.status}, 6'b100000);
    check("reset_counters", {bus.word_cnt, bus.bit_err_cnt}, 0);
    rst = 1'b1;
    tick();

    // Clean loopback, 1000-word window, no errors allowed
    start_and_lock("clean", 32'd1000, 48'd0);
    measure("clean", 1000, 0, 32'd0, -1, 48'd1000, 48'd0, ST_PASS);

    // start together with abort from DONE: abort wins, counters untouched
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("startabort_state", {bus.chain_rst, bus.busy, bus.done, bus.status}, 5'b10000);
    check("startabort_cnt_hold", bus.word_cnt, 48'd1000);

    // 5 words of 0x101 = 10 bit errors against limits 9 and 10
    start_and_lock("lim9", 32'd20, 48'd9);
    measure("lim9", 20, 5, 32'h0000_0101, -1, 48'd20, 48'd10, ST_FAIL);
    start_and_lock("lim10", 32'd20, 48'd10);
    bus.window_words = 32'd5;  // a start while busy must not relatch this
    measure("lim10", 20, 5, 32'h0000_0101, 7, 48'd20, 48'd10, ST_PASS);

    // Zero window means one word; all-ones vector, limit exactly equal
    start_and_lock("win0", 32'd0, 48'd32);
    measure("win0", 1, 1, 32'hFFFF_FFFF, -1, 48'd1, 48'd32, ST_PASS);

    // Error at run count 63 restarts the lock run
    start_chain("relock", 32'd3, 48'd0);
    repeat (256) tick();
    for (int i = 0; i < 127; i++) begin
      bus.chk_err = (i == 63) ? 32'h0000_0004 : 32'd0;
      tick();
    end
    check("relock_not_yet", bus.locked, 0);
    tick();
    check("relock_locked", bus.locked, 1);
    measure("relock", 3, 0, 32'd0, -1, 48'd3, 48'd0, ST_PASS);

    // Abort in the middle of MEASURE
    start_and_lock("abort", 32'd100, 48'd0);
    repeat (10) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_state", {bus.chain_rst, bus.busy, bus.status}, 4'b1000);
    check("abort_cnt_hold", bus.word_cnt, 48'd10);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.done) seen++;
      tick();
    end
    check("abort_no_done", seen, 0);

    // Block reset in the middle of MEASURE
    start_and_lock("rst", 32'd100, 48'd0);
    bus.chk_err = 32'h0000_0003;
    repeat (10) tick();
    rst = 1'b0;
    tick();
    check("midrst_outputs", {bus.chain_rst, bus.busy, bus.locked, bus.done, bus.status}, 6'b100000);
    check("midrst_counters", {bus.word_cnt, bus.bit_err_cnt}, 0);
    rst = 1'b1;
    bus.chk_err = '0;
    tick();

    // No checker data: timeout exactly LOCK_TIMEOUT cycles after LOCK entry
    start_chain("tmo", 32'd10, 48'd0);
    bus.chk_valid = 1'b0;
    repeat (256) tick();
    repeat (65535) tick();
    check("tmo_before", {bus.busy, bus.status}, 3'b100);
    tick();
    check("tmo_result", {bus.done, bus.busy, bus.locked, bus.status}, {3'b100, ST_TIMEOUT});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/loopback_ber_ctrl.md
# loopback_ber_ctrl

Test sequencer for the TX→RX loopback chain (PRBS gen → Encoder → Sync → DeSync → Decoder → PRBS checker). Holds the chain in reset, releases it, waits for the checker to lock onto the PRBS-31 stream, then counts words and bit errors over a programmed window. It also reports pass/fail/timeout. It sits in the `core_clk` domain beside the checker and replaces free-running bench counting.

## Interface
- `NBITS`, 32: checker error-vector width.
- `CNT_W`, 48: width of the word and bit-error counters.
- `CHAIN_RST_CYCLES`, 16: cycles `chain_rst` is held high.
- `WARMUP_CYCLES`, 256: cycles ignored after chain reset release, covering CDC FIFO and frame fill.
- `LOCK_WORDS`, 64: consecutive error-free valid words required to declare lock.
- `LOCK_TIMEOUT`, 65536: max cycles in LOCK before giving up.

Ports:
- `core_clk` in 1: single clock for all logic.
- `rst` in 1: **synchronous, active-low** block reset.
- `start` in 1: one-cycle pulse; begins a test. Ignored unless in IDLE or DONE.
- `abort` in 1: level; forces return to IDLE.
- `window_words` in 32: measurement length in valid words; latched on accepted `start`.
- `err_limit` in `CNT_W`: max bit errors still counted as pass; latched on `start`.
- `chk_valid` in 1: checker enable (decoder `output_tvalid`).
- `chk_err` in `NBITS`: checker error vector, 1 = bit error.
- `chain_rst` out 1: active-high reset to the datapath chain.
- `busy` out 1: high in every state except IDLE and DONE.
- `locked` out 1: high from lock declaration until the next `start`.
- `done` out 1: one-cycle pulse on entry to DONE.
- `status` out 2: 0 none, 1 pass, 2 fail (errors > limit), 3 lock timeout.
- `word_cnt` out `CNT_W`: valid words counted in MEASURE.
- `bit_err_cnt` out `CNT_W`: bit errors counted in MEASURE.

## Operation
- FSM states: IDLE → CHAIN_RST → WARMUP → LOCK → MEASURE → FLUSH → DONE.
- IDLE: `chain_rst`=1. Accepted `start` clears counters, `locked`, and `status`, latches the config, and enters CHAIN_RST.
- CHAIN_RST: `chain_rst`=1 for exactly `CHAIN_RST_CYCLES` cycles, then WARMUP.
- WARMUP: `chain_rst`=0. Waits `WARMUP_CYCLES` cycles; `chk_*` is ignored.
- LOCK: a run counter increments on each `chk_valid` with `chk_err`==0. It clears on `chk_valid` with any error bit set, and holds when `chk_valid`=0.
  - Run reaching `LOCK_WORDS` → `locked`=1, enter MEASURE.
  - `LOCK_TIMEOUT` cycles elapsed first → `status`=3, enter DONE.
- MEASURE: each `chk_valid` increments `word_cnt` by 1 and adds popcount(`chk_err`) to `bit_err_cnt` through a one-stage registered popcount. After `window_words` valid words, enter FLUSH.
- FLUSH: one cycle that lets the last popcount land. Then `status` = 1 if `bit_err_cnt` ≤ `err_limit`, else 2. Enter DONE.
- DONE: `chain_rst`=0 (chain keeps running). Counters and `status` hold until the next `start`.
- `window_words`==0 is treated as 1.
- Counters saturate at all-ones and never wrap.
- Loss of sync during MEASURE is not re-detected; it appears only as errors.
- `abort` high in any state → IDLE next cycle. `status`=0, no `done` pulse, counters hold.
- `start` and `abort` in the same cycle: `abort` wins.

## Timing
- Reset (`rst`=0 at a `core_clk` edge):
  - State = IDLE, `chain_rst`=1.
  - `busy`, `locked`, `done` = 0; `status`=0; counters = 0.
- `start` sampled in cycle T:
  - `chain_rst` and `busy` are high from T+1.
  - `chain_rst` falls at T+1+`CHAIN_RST_CYCLES`.
- Lock: the word that completes the run raises `locked` and enters MEASURE on the next edge. That word itself is not counted.
- `bit_err_cnt` updates one cycle after its `chk_valid` word. `word_cnt` updates in the same cycle as that word's registered effect.
- The last window word at cycle W gives FLUSH at W+1, and `done`/`status` valid at W+2.
- `chk_valid` during FLUSH or DONE is ignored.

## Structure
- Package `loopback_pkg`:
  - state enum;
  - status codes `ST_NONE`/`ST_PASS`/`ST_FAIL`/`ST_TIMEOUT`;
  - `CNT_W` default.
- Sub-module `popcount_reg` (parameter `NBITS`): combinational sum plus output register with enable. Reusable by other BER monitors.

## Test plan
- Clean loopback, `window_words`=1000, `err_limit`=0:
  - `chain_rst` high 16 cycles;
  - `locked` rises;
  - `word_cnt`=1000, `bit_err_cnt`=0, `status`=1, single `done` pulse.
- Inject error vector 0x0000_0101 on 5 measured words, `err_limit`=9 → `bit_err_cnt`=10, `status`=2. Same run with `err_limit`=10 → `status`=1.
- Error word at run count 63 during LOCK → run restarts; `locked` is asserted only after 64 further clean words.
- `chk_valid` held low → `status`=3 exactly `LOCK_TIMEOUT` cycles after LOCK entry; `locked`=0.
- `abort` mid-MEASURE, and `start`+`abort` in the same cycle → IDLE, `chain_rst`=1, `status`=0, no `done`.
- `rst` low mid-MEASURE → all outputs at their reset values next cycle. `start` during `busy` is ignored (counters unaffected).
